// File: rtl/mioc_top_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mioc_top_reg                                                 |
// | Description : MIOC top register cell: 4-bit shift/fill/rotate register     |
// |               with a complementary, register-driven q/qbar output pair.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mioc_top_reg (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  output logic q,
  output logic qbar
);

  localparam logic [1:0] c_OP_HOLD   = 2'b00;
  localparam logic [1:0] c_OP_SHIFT  = 2'b01;
  localparam logic [1:0] c_OP_FILL   = 2'b10;
  localparam logic [1:0] c_OP_ROTATE = 2'b11;

  logic [3:0] r_reg;
  logic [3:0] w_next;
  logic [1:0] w_op;

  assign w_op = {in1, in2};

  // in4 inhibits every opcode, so the default below doubles as the inhibit path.
  always_comb begin
    w_next = r_reg;
    if (!in4) begin
      case (w_op)
        c_OP_HOLD:   w_next = r_reg;
        c_OP_SHIFT:  w_next = {r_reg[2:0], in3};
        c_OP_FILL:   w_next = {4{in3}};
        c_OP_ROTATE: w_next = {r_reg[2:0], r_reg[3]};
        default:     w_next = r_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg <= 4'b0000;
    end else begin
      r_reg <= w_next;
    end
  end

  // Both outputs come straight from the register bit: no input-to-output path.
  assign q    = r_reg[3];
  assign qbar = ~r_reg[3];

endmodule
`default_nettype wire

// File: tb/tb_mioc_top_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mioc_top_reg                                              |
// | Description : Directed self-checking bench for mioc_top_reg.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mioc_top_reg;

  logic clk;
  logic rst;
  logic in1, in2, in3, in4;
  logic q, qbar;

  int   n_tests;
  int   n_fail;
  logic [3:0] m_reg;

  mioc_top_reg u_dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .q    (q),
    .qbar (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", tag, obs, exp);
    end
  endtask

  // nib = {in1,in2,in3,in4}; returns one time unit after the capturing edge
  task automatic apply(input logic [3:0] nib, input logic r);
    @(negedge clk);
    rst = r;
    {in1, in2, in3, in4} = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic exp_q);
    check({tag, ".q"}, q, exp_q);
    check({tag, ".qbar"}, qbar, ~exp_q);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    {in1, in2, in3, in4} = 4'b0000;

    apply(4'b1111, 1'b1);
    check_q("reset1", 1'b0);
    apply(4'b1111, 1'b1);
    check_q("reset2", 1'b0);

    apply(4'b0110, 1'b0);
    check_q("shift1", 1'b0);
    apply(4'b0100, 1'b0);
    check_q("shift2", 1'b0);
    apply(4'b0100, 1'b0);
    check_q("shift3", 1'b0);
    apply(4'b0100, 1'b0);
    check_q("shift4", 1'b1);

    apply(4'b1010, 1'b0);
    check_q("fill1", 1'b1);
    apply(4'b1001, 1'b0);
    check_q("inh_fill0", 1'b1);
    apply(4'b0111, 1'b0);
    check_q("inh_shift1", 1'b1);
    apply(4'b1111, 1'b0);
    check_q("inh_rot", 1'b1);
    apply(4'b1000, 1'b0);
    check_q("fill0", 1'b0);

    apply(4'b0110, 1'b0);
    apply(4'b0100, 1'b0);
    apply(4'b0100, 1'b0);
    apply(4'b0100, 1'b0);
    check_q("rot_load", 1'b1);
    apply(4'b1100, 1'b0);
    check_q("rot1", 1'b0);
    apply(4'b1100, 1'b0);
    check_q("rot2", 1'b0);
    apply(4'b1100, 1'b0);
    check_q("rot3", 1'b0);
    apply(4'b1100, 1'b0);
    check_q("rot4", 1'b1);

    apply(4'b1010, 1'b0);
    check_q("pre_rst_fill", 1'b1);
    apply(4'b1100, 1'b1);
    check_q("mid_rst", 1'b0);
    apply(4'b1100, 1'b0);
    check_q("post_rst_rot", 1'b0);

    // Sweep all 16 nibbles twice (forward, then reversed) against a small model.
    m_reg = 4'b0000;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] nib;
        nib = (pass == 0) ? 4'(i) : 4'(15 - i);
        if (!nib[0]) begin
          case (nib[3:2])
            2'b01:   m_reg = {m_reg[2:0], nib[1]};
            2'b10:   m_reg = {4{nib[1]}};
            2'b11:   m_reg = {m_reg[2:0], m_reg[3]};
            default: m_reg = m_reg;
          endcase
        end
        apply(nib, 1'b0);
        check_q($sformatf("sweep%0d_%0d", pass, nib), m_reg[3]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
